// File: rtl/txgfskshape_if.sv
// Bit-stream and deviation bundle between the TX bit assembler and the GFSK pulse shaper.
//
// Signals:
//   p_1us         one-cycle bit strobe, nominally every 6 clocks
//   txbit         serial TX bit, sampled when p_1us is high
//   txbit_period  marks txbit as part of a burst (only meaningful on p_1us)
//   freq_dev      signed two's-complement deviation word, full scale +/-64
//   tx_on         high while the shaper is transmitting or flushing
//   tx_bitcnt     valid bits accepted in the current burst
//
// Modports:
//   master  bit assembler side (drives the bit stream, observes the shaper)
//   slave   pulse shaper side
interface txgfskshape_if;
  logic              p_1us;
  logic              txbit;
  logic              txbit_period;
  logic signed [7:0] freq_dev;
  logic              tx_on;
  logic [10:0]       tx_bitcnt;

  modport master (
    output p_1us,
    output txbit,
    output txbit_period,
    input  freq_dev,
    input  tx_on,
    input  tx_bitcnt
  );

  modport slave (
    input  p_1us,
    input  txbit,
    input  txbit_period,
    output freq_dev,
    output tx_on,
    output tx_bitcnt
  );
endinterface

// File: rtl/txgfskshape.sv
// GFSK transmit pulse shaper.
//
// Consumes the serial txbit stream (one bit per p_1us strobe) and produces a signed frequency
// deviation word every clock using a 3-bit-span Gaussian-approximating FIR at 6 samples per
// bit. Bursts are sequenced Idle -> Active -> Flush -> Idle; the flush shifts invalid symbols
// through the history so the deviation tapers smoothly to zero before tx_on drops.
//
// Ports:
//   clk_6M  6 MHz system clock
//   rstz    asynchronous active-low reset
//   bus     txgfskshape_if.slave: p_1us/txbit/txbit_period in, freq_dev/tx_on/tx_bitcnt out
module txgfskshape (
  input logic          clk_6M,
  input logic          rstz,
  txgfskshape_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StFlush  = 2'd2
  } state_e;

  localparam logic [2:0]  PhLast = 3'd5;
  localparam logic [10:0] CntMax = 11'd2047;

  state_e            state_q;
  // History entries: index 0 = next, 1 = current, 2 = previous.
  logic [2:0]        hist_vld_q;
  logic [2:0]        hist_bit_q;
  logic [2:0]        ph_q;
  logic [1:0]        flush_cnt_q;
  logic signed [7:0] freq_dev_q;
  logic              tx_on_q;
  logic [10:0]       tx_bitcnt_q;

  logic              strobe_on;
  logic              strobe_off;
  logic [2:0]        hist_vld_shift;
  logic [2:0]        hist_bit_shift;
  logic [10:0]       bitcnt_inc;
  logic signed [7:0] f_sum;

  // Outer (next/previous) tap weights; a[ph] + b[ph] + a[5-ph] = 64 for every phase.
  function automatic logic [5:0] coef_a(input logic [2:0] p);
    logic [5:0] c;
    case (p)
      3'd0:    c = 6'd0;
      3'd1:    c = 6'd1;
      3'd2:    c = 6'd2;
      3'd3:    c = 6'd4;
      3'd4:    c = 6'd7;
      3'd5:    c = 6'd11;
      default: c = 6'd0;
    endcase
    return c;
  endfunction

  // Centre tap weights.
  function automatic logic [5:0] coef_b(input logic [2:0] p);
    logic [5:0] c;
    case (p)
      3'd0:    c = 6'd53;
      3'd1:    c = 6'd56;
      3'd2:    c = 6'd58;
      3'd3:    c = 6'd58;
      3'd4:    c = 6'd56;
      3'd5:    c = 6'd53;
      default: c = 6'd0;
    endcase
    return c;
  endfunction

  // Symbol times weight: +c for a valid 1, -c for a valid 0, 0 for an invalid slot.
  function automatic logic signed [7:0] weigh(input logic vld, input logic b,
                                              input logic [5:0] c);
    logic signed [7:0] mag;
    logic signed [7:0] res;
    mag = signed'({2'b00, c});
    if (!vld) begin
      res = 8'sd0;
    end else if (b) begin
      res = mag;
    end else begin
      res = -mag;
    end
    return res;
  endfunction

  always_comb begin
    strobe_on  = bus.p_1us & bus.txbit_period;
    strobe_off = bus.p_1us & ~bus.txbit_period;

    // New entry is valid only when the strobe carries a burst bit.
    hist_vld_shift = {hist_vld_q[1:0], strobe_on};
    hist_bit_shift = {hist_bit_q[1:0], bus.txbit & strobe_on};

    bitcnt_inc = (tx_bitcnt_q == CntMax) ? tx_bitcnt_q : tx_bitcnt_q + 11'd1;

    // The true sum always lies in +/-64, so 8-bit wrapping arithmetic is exact.
    f_sum = weigh(hist_vld_q[0], hist_bit_q[0], coef_a(ph_q))
          + weigh(hist_vld_q[1], hist_bit_q[1], coef_b(ph_q))
          + weigh(hist_vld_q[2], hist_bit_q[2], coef_a(PhLast - ph_q));
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q     <= StIdle;
      hist_vld_q  <= '0;
      hist_bit_q  <= '0;
      ph_q        <= '0;
      flush_cnt_q <= '0;
      freq_dev_q  <= '0;
      tx_on_q     <= 1'b0;
      tx_bitcnt_q <= '0;
    end else begin
      // Phase restarts on every strobe; late strobes park it on the last sample.
      if (bus.p_1us) begin
        ph_q <= '0;
      end else if (ph_q != PhLast) begin
        ph_q <= ph_q + 3'd1;
      end

      freq_dev_q <= f_sum;

      unique case (state_q)
        StIdle: begin
          if (strobe_on) begin
            hist_vld_q  <= hist_vld_shift;
            hist_bit_q  <= hist_bit_shift;
            tx_bitcnt_q <= 11'd1;
            tx_on_q     <= 1'b1;
            state_q     <= StActive;
          end
        end

        StActive: begin
          if (strobe_on) begin
            hist_vld_q  <= hist_vld_shift;
            hist_bit_q  <= hist_bit_shift;
            tx_bitcnt_q <= bitcnt_inc;
          end else if (strobe_off) begin
            hist_vld_q  <= hist_vld_shift;
            hist_bit_q  <= hist_bit_shift;
            flush_cnt_q <= 2'd2;
            state_q     <= StFlush;
          end
        end

        StFlush: begin
          if (strobe_on) begin
            // Burst resumes: the gap slot stays in the history as a zero symbol.
            hist_vld_q  <= hist_vld_shift;
            hist_bit_q  <= hist_bit_shift;
            tx_bitcnt_q <= bitcnt_inc;
            state_q     <= StActive;
          end else if (strobe_off) begin
            hist_vld_q  <= hist_vld_shift;
            hist_bit_q  <= hist_bit_shift;
            flush_cnt_q <= flush_cnt_q - 2'd1;
            if (flush_cnt_q == 2'd1) begin
              // Third invalid shift: history is empty, force a clean zero output.
              hist_vld_q <= '0;
              hist_bit_q <= '0;
              freq_dev_q <= '0;
              tx_on_q    <= 1'b0;
              state_q    <= StIdle;
            end
          end
        end

        default: begin
          hist_vld_q <= '0;
          hist_bit_q <= '0;
          tx_on_q    <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign bus.freq_dev  = freq_dev_q;
  assign bus.tx_on     = tx_on_q;
  assign bus.tx_bitcnt = tx_bitcnt_q;

endmodule
